// File: rtl/booth_pkg.sv
// Shared widths and state encoding for the booth multiply-accumulate path.
// Imported by the accumulator, its saturating adder and its interface.
package booth_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, burst result out, plus burst control.
// master drives start/len/products/acc_ready; slave is the accumulator.
interface product_accumulator_if
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              ovf;
  logic              busy;

  modport master (
    output start,
    output len,
    output prod,
    output prod_valid,
    input  prod_ready,
    input  acc_out,
    input  acc_valid,
    output acc_ready,
    input  ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  len,
    input  prod,
    input  prod_valid,
    output prod_ready,
    output acc_out,
    output acc_valid,
    input  acc_ready,
    output ovf,
    output busy
  );

endinterface

// File: rtl/product_accumulator_sat_add.sv
// Combinational two's-complement adder clamping to the ACC_W range.
// sat flags that the true sum did not fit.
module sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y,
  output logic             sat
);

  localparam logic [ACC_W-1:0] MAXV =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum;
  logic           pos_ovf;
  logic           neg_ovf;

  // One guard bit: top two bits differ exactly on overflow
  assign sum = {a[ACC_W-1], a}
             + {b[ACC_W-1], b};

  assign pos_ovf = ~sum[ACC_W] &  sum[ACC_W-1];
  assign neg_ovf =  sum[ACC_W] & ~sum[ACC_W-1];
  assign sat     = pos_ovf | neg_ovf;

  always_comb begin
    y = sum[ACC_W-1:0];
    unique case (1'b1)
      pos_ovf: y = MAXV;
      neg_ovf: y = MINV;
      default: y = sum[ACC_W-1:0];
    endcase
  end

endmodule

// File: rtl/product_accumulator.sv
// Burst accumulator for booth products with saturation and a held
// result; one product per cycle, result held until acc_ready.
module product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  product_accumulator_if.slave bus
);

  acc_state_t       state;
  acc_state_t       state_n;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf;
  logic             ovf_n;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             sat;

  assign prod_ext = {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}},
                     bus.prod};

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat (
    .a   (acc),
    .b   (prod_ext),
    .y   (sum),
    .sat (sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = bus.len;
          state_n = (bus.len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_n = sum;
          ovf_n = ovf | sat;
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.acc_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so reset clears them at once
  assign bus.prod_ready = (state == ACCUM);
  assign bus.acc_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.acc_out    = acc;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: 24-bit and 17-bit accumulators against a burst-level
// arithmetic model checked every falling edge, plus literal expectations.
module tb_product_accumulator;

  logic clk;
  logic rst;

  logic        st [2];
  logic [3:0]  ln [2];
  logic [15:0] pr [2];
  logic        pv [2];
  logic        ar [2];

  logic [23:0] o_acc [2];
  logic        o_rdy [2];
  logic        o_vld [2];
  logic        o_ovf [2];
  logic        o_bsy [2];

  int n_chk  = 0;
  int n_pass = 0;

  product_accumulator_if #(.ACC_W(24)) b0 ();
  product_accumulator_if #(.ACC_W(17)) b1 ();

  product_accumulator #(.ACC_W(24)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  product_accumulator #(.ACC_W(17)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  assign b0.start      = st[0];
  assign b0.len        = ln[0];
  assign b0.prod       = pr[0];
  assign b0.prod_valid = pv[0];
  assign b0.acc_ready  = ar[0];
  assign b1.start      = st[1];
  assign b1.len        = ln[1];
  assign b1.prod       = pr[1];
  assign b1.prod_valid = pv[1];
  assign b1.acc_ready  = ar[1];

  assign o_acc[0] = b0.acc_out;
  assign o_acc[1] = {7'd0, b1.acc_out};
  assign o_rdy[0] = b0.prod_ready;
  assign o_rdy[1] = b1.prod_ready;
  assign o_vld[0] = b0.acc_valid;
  assign o_vld[1] = b1.acc_valid;
  assign o_ovf[0] = b0.ovf;
  assign o_ovf[1] = b1.ovf;
  assign o_bsy[0] = b0.busy;
  assign o_bsy[1] = b1.busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Burst-level model: running true sum clamped to the width's range
  longint m_acc  [2] = '{0, 0};
  int     m_rem  [2] = '{0, 0};
  bit     m_busy [2] = '{0, 0};
  bit     m_hold [2] = '{0, 0};
  bit     m_ovf  [2] = '{0, 0};

  function automatic int width(int i);
    return (i == 0) ? 24 : 17;
  endfunction

  task automatic step(int i);
    longint p;
    longint s;
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (width(i) - 1)) - 1;
    mn = -mx - 1;
    if (!m_busy[i]) begin
      if (st[i]) begin
        m_acc[i]  = 0;
        m_ovf[i]  = 0;
        m_rem[i]  = int'(ln[i]);
        m_busy[i] = 1;
        m_hold[i] = (ln[i] == 4'd0);
      end
    end else if (m_hold[i]) begin
      if (ar[i]) begin
        m_busy[i] = 0;
        m_hold[i] = 0;
      end
    end else if (pv[i]) begin
      p = $signed(pr[i]);
      s = m_acc[i] + p;
      if (s > mx) begin
        s = mx;
        m_ovf[i] = 1;
      end else if (s < mn) begin
        s = mn;
        m_ovf[i] = 1;
      end
      m_acc[i] = s;
      m_rem[i] = m_rem[i] - 1;
      if (m_rem[i] == 0) m_hold[i] = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i]  = 0;
        m_rem[i]  = 0;
        m_busy[i] = 0;
        m_hold[i] = 0;
        m_ovf[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  task automatic cmp_all(string tag);
    longint mask;
    for (int i = 0; i < 2; i++) begin
      mask = (longint'(1) <<< width(i)) - 1;
      check($sformatf("%s.u%0d.busy", tag, i),
            64'(o_bsy[i]), 64'(m_busy[i]));
      check($sformatf("%s.u%0d.prod_ready", tag, i),
            64'(o_rdy[i]), 64'(m_busy[i] && !m_hold[i]));
      check($sformatf("%s.u%0d.acc_valid", tag, i),
            64'(o_vld[i]), 64'(m_hold[i]));
      check($sformatf("%s.u%0d.acc_out", tag, i),
            64'(o_acc[i]), 64'(m_acc[i] & mask));
      check($sformatf("%s.u%0d.ovf", tag, i),
            64'(o_ovf[i]), 64'(m_ovf[i]));
    end
  endtask

  always @(negedge clk) cmp_all("cyc");

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; ln[i] = 0; pr[i] = 0;
      pv[i] = 0; ar[i] = 0;
    end
    tick();
    tick();
    check("rst_busy",  64'(o_bsy[0]), 64'd0);
    check("rst_valid", 64'(o_vld[0]), 64'd0);
    check("rst_ready", 64'(o_rdy[0]), 64'd0);
    check("rst_acc",   64'(o_acc[0]), 64'd0);
    rst = 1'b0;

    // Simple burst of four +1 products
    st[0] = 1; ln[0] = 4;
    tick();
    st[0] = 0; pv[0] = 1; pr[0] = 16'h0001;
    repeat (3) tick();
    check("b1_valid_early", 64'(o_vld[0]), 64'd0);
    check("b1_acc_partial", 64'(o_acc[0]), 64'h3);
    tick();
    pv[0] = 0;
    check("b1_valid", 64'(o_vld[0]), 64'd1);
    check("b1_acc",   64'(o_acc[0]), 64'h000004);
    check("b1_ovf",   64'(o_ovf[0]), 64'd0);
    ar[0] = 1;
    tick();
    ar[0] = 0;
    check("b1_idle",  64'(o_vld[0]), 64'd0);
    check("b1_keep",  64'(o_acc[0]), 64'h000004);

    // Mixed signs with a bubble
    st[0] = 1; ln[0] = 3;
    tick();
    st[0] = 0; pv[0] = 1; pr[0] = 16'h7FFF;
    tick();
    pv[0] = 0;
    tick();
    pv[0] = 1; pr[0] = 16'h8000;
    tick();
    pr[0] = 16'hFFFF;
    tick();
    pv[0] = 0;
    check("b2_acc", 64'(o_acc[0]), 64'hFFFFFE);
    check("b2_ovf", 64'(o_ovf[0]), 64'd0);
    ar[0] = 1;
    tick();
    ar[0] = 0;

    // Zero length with backpressure and ignored starts
    st[0] = 1; ln[0] = 0;
    tick();
    st[0] = 0;
    check("z_valid", 64'(o_vld[0]), 64'd1);
    check("z_acc",   64'(o_acc[0]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      st[0] = k[0]; ln[0] = 4'd5;
      tick();
      check("z_hold_valid", 64'(o_vld[0]), 64'd1);
      check("z_hold_acc",   64'(o_acc[0]), 64'd0);
    end
    st[0] = 0;
    ar[0] = 1;
    tick();
    ar[0] = 0;
    check("z_done", 64'(o_bsy[0]), 64'd0);

    // Positive saturation at 17 bits, held under backpressure
    st[1] = 1; ln[1] = 3;
    tick();
    st[1] = 0; pv[1] = 1; pr[1] = 16'h7FFF;
    repeat (3) tick();
    pv[1] = 0;
    for (int k = 0; k < 5; k++) begin
      check("sp_acc", 64'(o_acc[1]), 64'h0FFFF);
      check("sp_ovf", 64'(o_ovf[1]), 64'd1);
      tick();
    end
    ar[1] = 1;
    tick();
    ar[1] = 0;
    check("sp_ovf_sticky", 64'(o_ovf[1]), 64'd1);

    // Negative saturation at 17 bits
    st[1] = 1; ln[1] = 3;
    tick();
    st[1] = 0;
    check("sn_ovf_clr", 64'(o_ovf[1]), 64'd0);
    pv[1] = 1; pr[1] = 16'h8000;
    repeat (3) tick();
    pv[1] = 0;
    check("sn_acc", 64'(o_acc[1]), 64'h10000);
    check("sn_ovf", 64'(o_ovf[1]), 64'd1);
    ar[1] = 1;
    tick();
    ar[1] = 0;

    // Reset part-way through a burst, between clock edges
    st[0] = 1; ln[0] = 4;
    tick();
    st[0] = 0; pv[0] = 1; pr[0] = 16'h0003;
    repeat (2) tick();
    pv[0] = 0;
    #2 rst = 1'b1;
    #1;
    check("mr_busy",  64'(o_bsy[0]), 64'd0);
    check("mr_valid", 64'(o_vld[0]), 64'd0);
    check("mr_ready", 64'(o_rdy[0]), 64'd0);
    check("mr_acc",   64'(o_acc[0]), 64'd0);
    check("mr_ovf1",  64'(o_ovf[1]), 64'd0);
    tick();
    rst = 1'b0;
    st[0] = 1; ln[0] = 1;
    tick();
    st[0] = 0; pv[0] = 1; pr[0] = 16'h0005;
    tick();
    pv[0] = 0;
    check("mr_new_valid", 64'(o_vld[0]), 64'd1);
    check("mr_new_acc",   64'(o_acc[0]), 64'h000005);
    ar[0] = 1;
    tick();
    ar[0] = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
